sram_tester: RTL and testbench

Built-in self-test sequencer for the external 256K×16 SRAM on the Hack board. It is the stage directly upstream of `SRAM_Controller`: it issues write and read requests through the controller's request/acknowledge interface, writes a deterministic address-derived pattern, reads it back and compares it. It reports busy, done, pass/fail, and the first mismatch to the board top level, which drives the LEDs from these outputs and launches a run from a button.

---
 rtl/sram_tester.sv | 140 ++++++++++++++
 tb/tb_sram_tester.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_tester.sv
// Built-in self-test sequencer for the external SRAM. Writes an address-derived
// pattern in two passes (true and inverted), reads each pass back through the
// SRAM_Controller request/ack handshake and records mismatches.
module sram_tester #(
   parameter int unsigned ADDR_W    = 18,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned LAST_ADDR = 2**18-1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [15:0]       err_count,
   output logic [ADDR_W-1:0] err_addr,
   output logic [DATA_W-1:0] err_data
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

   // Test pattern: low address bits folded with the top two, inverted on pass 1.
   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic p);
      logic [17:0] a18;
      logic [15:0] v;
      a18 = 18'(a);
      v   = a18[15:0] ^ {14'b0, a18[17:16]} ^ {16{p}};
      return DATA_W'(v);
   endfunction

   logic [1:0]        state_q, state_d;
   logic              phase_q, phase_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       err_count_q, err_count_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic [DATA_W-1:0] err_data_q, err_data_d;

   // Next-state: launch, address walk, phase sequencing and read-back compare.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      addr_d      = addr_q;
      err_count_d = err_count_q;
      err_addr_d  = err_addr_q;
      err_data_d  = err_data_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_WRITE;
               phase_d     = 1'b0;
               addr_d      = '0;
               err_count_d = '0;
               err_addr_d  = '0;
               err_data_d  = '0;
            end
         end
         S_WRITE: begin
            if (mem_ack) begin
               if (addr_q == LAST) begin
                  state_d = S_READ;
                  addr_d  = '0;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         S_READ: begin
            if (mem_ack) begin
               if (mem_rdata != pat(addr_q, phase_q)) begin
                  if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
                  // Only the first mismatch of a run is captured.
                  if (err_count_q == 16'd0) begin
                     err_addr_d = addr_q;
                     err_data_d = mem_rdata;
                  end
               end
               if (addr_q == LAST) begin
                  if (!phase_q) begin
                     state_d = S_WRITE;
                     phase_d = 1'b1;
                     addr_d  = '0;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; async reset clears everything, which drops mem_req at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         phase_q     <= 1'b0;
         addr_q      <= '0;
         err_count_q <= '0;
         err_addr_q  <= '0;
         err_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         addr_q      <= addr_d;
         err_count_q <= err_count_d;
         err_addr_q  <= err_addr_d;
         err_data_q  <= err_data_d;
      end
   end

   // Outputs decoded straight from registered state, so they only move on edges.
   always_comb begin
      mem_req   = (state_q == S_WRITE) || (state_q == S_READ);
      mem_we    = (state_q == S_WRITE);
      mem_addr  = addr_q;
      mem_wdata = (state_q == S_WRITE) ? pat(addr_q, phase_q) : '0;
      busy      = mem_req;
      done      = (state_q == S_DONE);
      pass      = done && (err_count_q == 16'd0);
      fail      = done && (err_count_q != 16'd0);
      err_count = err_count_q;
      err_addr  = err_addr_q;
      err_data  = err_data_q;
   end

endmodule

// File: tb/tb_sram_tester.sv
// Scoreboarded bench for sram_tester: a behavioural SRAM with fault injection
// answers requests; expected requests are queued at launch and popped per ack.
module tb_sram_tester;

   localparam int LAST = 15;
   localparam int N    = LAST + 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        mem_ack = 1'b0;
   logic [15:0] mem_rdata = 16'h0;
   logic        mem_req, mem_we, busy, done, pass, fail;
   logic [17:0] mem_addr, err_addr;
   logic [15:0] mem_wdata, err_count, err_data;

   sram_tester #(.ADDR_W(18), .DATA_W(16), .LAST_ADDR(LAST)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .pass(pass), .fail(fail),
      .err_count(err_count), .err_addr(err_addr), .err_data(err_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [17:0] addr;
      logic [15:0] wdata;
   } req_t;

   req_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          mode = 0;
   bit          rand_lat = 1'b0;
   int          fixed_lat = 2;
   bit          spur_en = 1'b0;
   int          ack_cnt = 0;
   logic [15:0] mem[N];
   logic [15:0] cmask[N];

   function automatic logic [15:0] ref_pat(input int a, input int p);
      return 16'(a % 65536) ^ 16'((a / 65536) % 4) ^ ((p != 0) ? 16'hFFFF : 16'h0000);
   endfunction

   // Environment faults applied on the SRAM read path.
   function automatic logic [15:0] fault(input int a, input logic [15:0] v);
      case (mode)
         1: return (a == 5) ? (v & 16'hFFF7) : v;
         2: return (a == 3 || a == 9) ? (v ^ 16'h0101) : v;
         3: return v ^ cmask[a];
         default: return v;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_run();
      for (int p = 0; p < 2; p++) begin
         for (int a = 0; a < N; a++) exp_q.push_back('{we: 1'b1, addr: 18'(a), wdata: ref_pat(a, p)});
         for (int a = 0; a < N; a++) exp_q.push_back('{we: 1'b0, addr: 18'(a), wdata: 16'h0});
      end
   endtask

   task automatic wait_done(input bit drop_start, output int cyc);
      cyc = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (drop_start) start = 1'b0;
         if (done) return;
      end
      tests++;
      fails++;
      $display("FAIL done_timeout: got done=0 after 4000 cycles, expected done=1");
   endtask

   // Expected end-of-run result from the fault model over the whole W/R sequence.
   task automatic check_result(input string tag);
      int          ec = 0;
      int          ea = 0;
      logic [15:0] ed = 16'h0;
      logic [15:0] v;
      for (int p = 0; p < 2; p++)
         for (int a = 0; a < N; a++) begin
            v = fault(a, ref_pat(a, p));
            if (v != ref_pat(a, p)) begin
               if (ec == 0) begin
                  ea = a;
                  ed = v;
               end
               ec++;
            end
         end
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_req"}, 32'(mem_req), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'(ec == 0));
      chk({tag, "_fail"}, 32'(fail), 32'(ec != 0));
      chk({tag, "_err_count"}, 32'(err_count), 32'(ec));
      chk({tag, "_err_addr"}, 32'(err_addr), 32'(ea));
      chk({tag, "_err_data"}, 32'(err_data), 32'(ed));
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_once(input string tag);
      int cyc;
      @(negedge clk);
      start = 1'b1;
      push_run();
      wait_done(1'b1, cyc);
      check_result(tag);
   endtask

   // Behavioural SRAM: acks after a latency, checks request stability meanwhile.
   initial begin
      int   lat;
      int   a;
      req_t cap;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (mem_req) begin
            cap = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
            lat = rand_lat ? int'($urandom_range(1, 5)) : fixed_lat;
            for (int k = 1; k < lat; k++) begin
               @(posedge clk);
               #1;
               if (!mem_req) break;
               chk("hold_we", 32'(mem_we), 32'(cap.we));
               chk("hold_addr", 32'(mem_addr), 32'(cap.addr));
               chk("hold_wdata", 32'(mem_wdata), 32'(cap.wdata));
            end
            if (mem_req) begin
               a = int'(mem_addr);
               if (mem_we) begin
                  if (a < N) mem[a] = mem_wdata;
               end else begin
                  mem_rdata = (a < N) ? fault(a, mem[a]) : 16'hDEAD;
               end
               mem_ack = 1'b1;
            end
         end else if (spur_en && $urandom_range(0, 3) == 0) begin
            mem_rdata = 16'($urandom);
            mem_ack   = 1'b1;
         end
      end
   end

   // Monitor: every accepted request is popped and compared in order.
   initial begin
      req_t e;
      forever begin
         @(negedge clk);
         if (reset_n && mem_req && mem_ack) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_request: got addr %0h we %0b, expected none", mem_addr, mem_we);
            end else begin
               e = exp_q.pop_front();
               chk("req_we", 32'(mem_we), 32'(e.we));
               chk("req_addr", 32'(mem_addr), 32'(e.addr));
               chk("req_wdata", 32'(mem_wdata), 32'(e.wdata));
            end
         end
      end
   end

   initial begin
      int cyc;
      int base;
      for (int a = 0; a < N; a++) begin
         mem[a]   = 16'($urandom);
         cmask[a] = 16'h0;
      end
      #12;
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_outputs", {mem_we, busy, done, pass, fail, mem_wdata}, 0);
      chk("rst_err", {err_count, err_addr[15:0]}, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Clean run with fixed 2-cycle latency; done lands 129 edges in, counting launch.
      mode = 0;
      fixed_lat = 2;
      @(negedge clk);
      start = 1'b1;
      push_run();
      wait_done(1'b1, cyc);
      chk("clean_cycles", 32'(cyc), 32'd129);
      check_result("clean");

      // Stuck-at-0 bit 3 at address 5, random latency and spurious idle acks.
      rand_lat = 1'b1;
      spur_en  = 1'b1;
      mode     = 1;
      run_once("stuck");
      chk("stuck_err_data_value", 32'(err_data), 32'h0000FFF2);

      mode = 2;
      run_once("multi");
      chk("multi_err_data_value", 32'(err_data), 32'h00000102);

      // Random per-address corruption.
      mode = 3;
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < N; a++)
            cmask[a] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0;
         run_once("random");
      end

      // Start held through the run, then relaunch straight out of DONE.
      mode = 2;
      @(negedge clk);
      start = 1'b1;
      push_run();
      wait_done(1'b0, cyc);
      check_result("held");
      push_run();
      @(negedge clk);
      chk("relaunch_busy", 32'(busy), 32'd1);
      chk("relaunch_done", 32'(done), 32'd0);
      chk("relaunch_req", {mem_req, mem_we, 14'(mem_addr), mem_wdata}, 32'hC0000000);
      chk("relaunch_clear", {err_count, err_data}, 32'd0);
      chk("relaunch_clear_addr", 32'(err_addr), 32'd0);
      wait_done(1'b1, cyc);
      check_result("relaunch");

      // Start pulse during W1 must be ignored.
      mode = 0;
      base = ack_cnt;
      @(negedge clk);
      start = 1'b1;
      push_run();
      for (int i = 0; i < 2000 && (ack_cnt - base) < 40; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1'b1, cyc);
      check_result("pulse_w1");

      // Asynchronous reset during R0 at address 7.
      base = ack_cnt;
      @(negedge clk);
      start = 1'b1;
      push_run();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (mem_req && !mem_we && mem_addr == 18'd7 && (ack_cnt - base) >= 16) break;
      end
      chk("reset_at_r0_7", {mem_req, mem_we, 14'(mem_addr)}, 32'h00008007);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_req", 32'(mem_req), 0);
      chk("midrst_outputs", {mem_we, busy, done, pass, fail, mem_wdata}, 0);
      chk("midrst_addr", 32'(mem_addr), 0);
      chk("midrst_err", {err_count, err_data}, 0);
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("post_rst_idle", {mem_req, busy, done}, 0);
      end
      run_once("recover");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
